// File: rtl/fft_pkg.sv
// Shared FFT definitions: float32 layout, constant encodings, FSM states and
// the elaboration-time helpers that build the quarter-wave cosine table.
package fft_pkg;

    localparam int BITS     = 32;
    localparam int SIGN_BIT = BITS - 1;

    localparam logic [BITS-1:0] FLOAT_ZERO = 32'h0000_0000;
    localparam logic [BITS-1:0] FLOAT_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Taylor series for cos(x), x in [0, pi/2]; 15 terms are far below float32 resolution.
    function automatic real cos_series(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Round-to-nearest conversion of a value in [0, 1] to float32 bits.
    function automatic logic [BITS-1:0] real_to_float(input real x);
        real m;
        int  e;
        int  mant;
        if (x <= 0.0) return FLOAT_ZERO;
        if (x >= 1.0) return FLOAT_ONE;
        m = x;
        e = 0;
        while (m < 1.0) begin
            m = m * 2.0;
            e = e - 1;
        end
        mant = int'(m * 8388608.0);
        if (mant >= 16777216) begin
            mant = 8388608;
            e    = e + 1;
        end
        return {1'b0, 8'(e + 127), 23'(mant)};
    endfunction

    // Table entry c[m] = cos(2*pi*m/N); the quarter point and padding entries are exact +0.
    function automatic logic [BITS-1:0] cos_entry(input int m, input int log2n);
        real ang;
        if (m == 0) return FLOAT_ONE;
        if (m >= (1 << (log2n - 2))) return FLOAT_ZERO;
        ang = 6.283185307179586 * real'(m) / real'(1 << log2n);
        return real_to_float(cos_series(ang));
    endfunction

endpackage

// File: rtl/twiddle_seq_if.sv
// Twiddle stream bus between the sequencer (master) and the butterfly unit (slave).
interface twiddle_seq_if import fft_pkg::*; #(
    parameter int LOG2N = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_re;
    logic [BITS-1:0]  out_im;
    logic [LOG2N-2:0] out_k;
    logic             out_last;

    modport master (
        output out_valid, out_re, out_im, out_k, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_re, out_im, out_k, out_last,
        output out_ready
    );
endinterface

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine ROM, c[m] = cos(2*pi*m/N) for m = 0..N/4, two registered
// read ports (real and imaginary lookups). Contents are computed at elaboration
// for the configured LOG2N; entries past N/4 read as +0.
module twiddle_quarter_rom import fft_pkg::*; #(
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             en,
    input  logic [LOG2N-2:0] addr_a,
    input  logic [LOG2N-2:0] addr_b,
    output logic [BITS-1:0]  data_a,
    output logic [BITS-1:0]  data_b
);
    localparam int DEPTH = 1 << (LOG2N - 1);

    logic [BITS-1:0] rom_table [DEPTH];

    for (genvar m = 0; m < DEPTH; m++) begin : g_entry
        localparam logic [BITS-1:0] VALUE = cos_entry(m, LOG2N);
        assign rom_table[m] = VALUE;
    end

    // Registered read, stalled together with the rest of the pipe.
    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom_table[addr_a];
            data_b <= rom_table[addr_b];
        end
    end
endmodule

// File: rtl/twiddle_seq.sv
// Per-stage twiddle sequencer for the radix-2 DIT FFT. Streams N/2 float32
// twiddles W_N^k per stage, folding k onto a quarter-wave cosine table.
// Optional macro TWIDDLE_INVERSE_EN adds the `inverse` port (conjugate output).
module twiddle_seq import fft_pkg::*; #(
    parameter int LOG2N = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [$clog2(LOG2N)-1:0] stage,
`ifdef TWIDDLE_INVERSE_EN
    input  logic                     inverse,
`endif
    output logic                     busy,
    output logic                     done,
    twiddle_seq_if.master            tw
);
    localparam int KW      = LOG2N - 1;
    localparam int AW      = LOG2N - 1;
    localparam int SW      = $clog2(LOG2N);
    localparam int HALF    = 1 << (LOG2N - 1);
    localparam int QUARTER = 1 << (LOG2N - 2);

    state_t          state;
    logic [SW-1:0]   s_q;
    logic [KW-1:0]   j_q;
    logic            advance;
    logic            issue_en;
    logic [KW-1:0]   issue_j;
    logic [SW-1:0]   issue_s;
    logic [KW-1:0]   mask_c;
    logic [KW-1:0]   k_c;
    logic [AW-1:0]   addr_re_c;
    logic [AW-1:0]   addr_im_c;
    logic            neg_re_c;
    logic            im_neg;
    logic            vld_p1;
    logic [KW-1:0]   k_p1;
    logic            neg_re_p1;
    logic            last_p1;
    logic [BITS-1:0] rom_re;
    logic [BITS-1:0] rom_im;

    // Out-of-range stage indices collapse onto the final stage.
    function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
        if (int'(s) >= LOG2N) return SW'(LOG2N - 1);
        return s;
    endfunction

    // Sign by bit-31 flip; a zero magnitude is always emitted as +0.
    function automatic logic [BITS-1:0] apply_sign(input logic [BITS-1:0] mag, input logic neg);
        if (mag[SIGN_BIT-1:0] == '0) return FLOAT_ZERO;
        return {mag[SIGN_BIT] ^ neg, mag[SIGN_BIT-1:0]};
    endfunction

    // The whole pipe moves whenever the output register is free or being taken.
    assign advance = !tw.out_valid || tw.out_ready;

    // Select the butterfly index entering the pipe; j=0 goes in on the start edge.
    always_comb begin
        issue_en = 1'b0;
        issue_j  = j_q;
        issue_s  = s_q;
        if (state == ST_IDLE) begin
            issue_en = start;
            issue_j  = '0;
            issue_s  = clamp_stage(stage);
        end else if (state == ST_RUN) begin
            issue_en = advance;
        end
    end

    // Twiddle exponent and quarter-wave folding onto ROM addresses.
    always_comb begin
        int ki;
        mask_c = (KW'(1) << issue_s) - KW'(1);
        k_c    = KW'((issue_j & mask_c) << (KW - int'(issue_s)));
        ki     = int'(k_c);
        if (ki <= QUARTER) begin
            addr_re_c = AW'(ki);
            neg_re_c  = 1'b0;
            addr_im_c = AW'(QUARTER - ki);
        end else begin
            addr_re_c = AW'(HALF - ki);
            neg_re_c  = 1'b1;
            addr_im_c = AW'(ki - QUARTER);
        end
    end

    // Stage FSM: counter, busy and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s_q   <= '0;
            j_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        s_q   <= clamp_stage(stage);
                        j_q   <= KW'(1);
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        j_q <= j_q + KW'(1);
                        if (&j_q) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (tw.out_valid && tw.out_ready && tw.out_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TWIDDLE_INVERSE_EN
    logic inv_q;

    // Conjugate selection is fixed for the whole stage.
    always_ff @(posedge clk) begin
        if (!rst_n)                        inv_q <= 1'b0;
        else if (state == ST_IDLE && start) inv_q <= inverse;
    end

    assign im_neg = ~inv_q;
`else
    assign im_neg = 1'b1;
`endif

    twiddle_quarter_rom #(.LOG2N(LOG2N)) u_rom (
        .clk    (clk),
        .en     (advance),
        .addr_a (addr_re_c),
        .addr_b (addr_im_c),
        .data_a (rom_re),
        .data_b (rom_im)
    );

    // ---- P1: folded address into ROM, sign flag and side info ----
    always_ff @(posedge clk) begin
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (advance) vld_p1 <= issue_en;
    end

    // P1 side data travelling with the ROM read.
    always_ff @(posedge clk) begin
        if (advance) begin
            k_p1      <= k_c;
            neg_re_p1 <= neg_re_c;
            last_p1   <= &issue_j;
        end
    end

    // ---- P2: sign/zero fixup into the output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tw.out_valid <= 1'b0;
            tw.out_re    <= FLOAT_ZERO;
            tw.out_im    <= FLOAT_ZERO;
            tw.out_k     <= '0;
            tw.out_last  <= 1'b0;
        end else if (advance) begin
            tw.out_valid <= vld_p1;
            tw.out_re    <= apply_sign(rom_re, neg_re_p1);
            tw.out_im    <= apply_sign(rom_im, im_neg);
            tw.out_k     <= k_p1;
            tw.out_last  <= last_p1 && vld_p1;
        end
    end
endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq at N=16. Expected twiddles come from a
// hand-computed table; the monitor pops one entry per accepted output.
module tb_twiddle_seq;
    import fft_pkg::*;

    localparam int LOG2N = 4;
    localparam int KW    = LOG2N - 1;
    localparam int SW    = $clog2(LOG2N);
    localparam int NOUT  = 1 << (LOG2N - 1);

    typedef struct packed {
        logic [31:0]   re;
        logic [31:0]   im;
        logic [KW-1:0] k;
        logic          last;
    } tw_t;

    localparam logic [31:0] RE_TAB [8] = '{
        32'h3F800000, 32'h3F6C835E, 32'h3F3504F3, 32'h3EC3EF15,
        32'h00000000, 32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E};
    localparam logic [31:0] IM_TAB [8] = '{
        32'h00000000, 32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E,
        32'hBF800000, 32'hBF6C835E, 32'hBF3504F3, 32'hBEC3EF15};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] stage = '0;
`ifdef TWIDDLE_INVERSE_EN
    logic          inverse = 1'b0;
`endif
    logic          busy;
    logic          done;

    twiddle_seq_if #(.LOG2N(LOG2N)) tw();

    twiddle_seq #(.LOG2N(LOG2N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stage (stage),
`ifdef TWIDDLE_INVERSE_EN
        .inverse (inverse),
`endif
        .busy  (busy),
        .done  (done),
        .tw    (tw)
    );

    always #5 clk = ~clk;

    int  checks      = 0;
    int  errors      = 0;
    int  cyc         = 0;
    int  hs_last_cyc = -100;
    tw_t exp_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_stage(input int s, input bit inv, input int count);
        tw_t e;
        int  k;
        for (int j = 0; j < count; j++) begin
            k      = (j % (1 << s)) << (KW - s);
            e.re   = RE_TAB[k];
            e.im   = IM_TAB[k];
            if (inv && e.im != 32'h0) e.im[31] = ~e.im[31];
            e.k    = KW'(k);
            e.last = (j == NOUT - 1);
            exp_q.push_back(e);
        end
    endtask

    // Pulses start, then checks busy rise and first-valid latency.
    task automatic do_start(input int s, input bit inv);
        @(posedge clk); #2;
        start = 1'b1;
        stage = SW'(s);
`ifdef TWIDDLE_INVERSE_EN
        inverse = inv;
`else
        if (inv) $display("note: inverse requested without TWIDDLE_INVERSE_EN");
`endif
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", 96'(busy), 96'(1));
        check("valid_not_yet", 96'(tw.out_valid), 96'(0));
        @(posedge clk); #2;
        check("first_valid_latency", 96'(tw.out_valid), 96'(1));
        check("first_k_zero", 96'(tw.out_k), 96'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 96'(0), 96'(1));
        end else begin
            check("done_after_last", 96'(cyc), 96'(hs_last_cyc + 1));
            check("busy_low_at_done", 96'(busy), 96'(0));
            @(negedge clk);
            check("done_single_pulse", 96'(done), 96'(0));
        end
        check("queue_drained", 96'(exp_q.size()), 96'(0));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every accepted output is compared against the queue head.
    initial forever begin
        tw_t want;
        @(negedge clk);
        if (rst_n && tw.out_valid && tw.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got k=%0d re=%h im=%h with nothing expected",
                         tw.out_k, tw.out_re, tw.out_im);
            end else begin
                want = exp_q.pop_front();
                if ({tw.out_re, tw.out_im, tw.out_k, tw.out_last} !== want) begin
                    errors++;
                    $display("FAIL twiddle: got re=%h im=%h k=%0d last=%b expected re=%h im=%h k=%0d last=%b",
                             tw.out_re, tw.out_im, tw.out_k, tw.out_last,
                             want.re, want.im, want.k, want.last);
                end
            end
            if (tw.out_last) hs_last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tw.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_valid", 96'(tw.out_valid), 96'(0));
        check("rst_re", 96'(tw.out_re), 96'(0));
        check("rst_im", 96'(tw.out_im), 96'(0));
        check("rst_k_last", 96'({tw.out_k, tw.out_last}), 96'(0));
        rst_n = 1'b1;

        // Stage 0: every twiddle is W^0.
        push_stage(0, 1'b0, NOUT);
        do_start(0, 1'b0);
        wait_done();

        // Stage 3: k = 0..7.
        push_stage(3, 1'b0, NOUT);
        do_start(3, 1'b0);
        wait_done();

        // Stage 2: k = 0,2,4,6,0,2,4,6.
        push_stage(2, 1'b0, NOUT);
        do_start(2, 1'b0);
        wait_done();

        // Backpressure at k=1 of stage 3, with a start issued mid-stage.
        push_stage(3, 1'b0, NOUT);
        do_start(3, 1'b0);
        @(posedge clk); #2;
        check("bp_at_k1", 96'(tw.out_k), 96'(1));
        tw.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("bp_hold_valid", 96'(tw.out_valid), 96'(1));
            check("bp_hold_re", 96'(tw.out_re), 96'(32'h3F6C835E));
            check("bp_hold_im", 96'(tw.out_im), 96'(32'hBEC3EF15));
            check("bp_hold_k", 96'(tw.out_k), 96'(1));
            if (i == 0) begin
                start = 1'b1;
                stage = SW'(0);
            end else begin
                start = 1'b0;
            end
        end
        tw.out_ready = 1'b1;
        check("bp_busy_kept", 96'(busy), 96'(1));
        wait_done();

`ifdef TWIDDLE_INVERSE_EN
        // Conjugate twiddles, zero stays +0.
        push_stage(3, 1'b1, NOUT);
        do_start(3, 1'b1);
        wait_done();
`endif

        // Reset asserted while output 3 is presented.
        push_stage(3, 1'b0, 3);
        do_start(3, 1'b0);
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("pre_reset_k3", 96'(tw.out_k), 96'(3));
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_valid", 96'(tw.out_valid), 96'(0));
        check("mid_rst_re_im", 96'({tw.out_re, tw.out_im}), 96'(0));
        check("mid_rst_k_last", 96'({tw.out_k, tw.out_last}), 96'(0));
        check("mid_rst_busy_done", 96'({busy, done}), 96'(0));
        rst_n = 1'b1;
        check("mid_rst_queue", 96'(exp_q.size()), 96'(0));

        // Clean restart after reset.
        push_stage(3, 1'b0, NOUT);
        do_start(3, 1'b0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
